pipeline_hazard_unit: RTL and testbench
=======================================

Name: pipeline_hazard_unit

Overview:
- Producer of stall and flush controls for the 5-stage MIPS pipeline. It resolves every RAW case that operand forwarding cannot cover: load-use in EX, ID-stage branch or jr operands waiting on a load, and HI/LO access while the multi-cycle multiply/divide unit is busy.
- Drives the PC, IF/ID and ID/EX register enables and flushes.
- Keeps a busy counter for the mul/div unit and a saturating stall-cycle performance counter.

Parameters:
- MULDIV_CYCLES, 32, cycles mul/div occupies HI/LO after issue from EX (2..255).
- CNT_W, 32, width of stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_rs  in  5  rs field of instruction in ID.
- ID_rt  in  5  rt field of instruction in ID.
- ID_UsesRs  in  1  ID instruction reads rs.
- ID_UsesRt  in  1  ID instruction reads rt.
- BranchType  in  3  non-zero = conditional branch in ID.
- ID_PCSrc  in  2  00 sequential; 01/10 branch-taken/jump; 11 jr.
- ID_ReadHiLo  in  1  mfhi/mflo in ID.
- ID_MulDiv  in  1  mult/div in ID.
- EX_Rw  in  5  EX destination register.
- EX_RegWrite  in  1  EX instruction writes register.
- EX_MemRead  in  1  EX instruction is a load.
- MEM_Rw  in  5  MEM destination register.
- MEM_MemRead  in  1  MEM instruction is a load.
- EX_MulDivStart  in  1  mult/div issuing in EX this cycle.
- PC_Write  out  1  PC enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_ID_Flush  out  1  zero IF/ID (squash fetched instruction).
- ID_EX_Flush  out  1  insert bubble into ID/EX.
- MulDivBusy  out  1  HI/LO not yet valid.
- StallCycles  out  CNT_W  count of stalled cycles.

Behaviour:
- Reset (async, rst_n=0): busy counter=0, StallCycles=0, MulDivBusy=0. With no hazard inputs, outputs are PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0.
- matchEX_rs = ID_UsesRs && ID_rs==EX_Rw && EX_Rw!=0. Define matchEX_rt, matchMEM_rs and matchMEM_rt analogously.
- Load-use: load_stall = EX_MemRead && (matchEX_rs || matchEX_rt).
- Branch operands are compared in ID, so:
  - br_id = BranchType!=0 || ID_PCSrc==11.
  - br_stall = br_id && ((EX_MemRead && (matchEX_rs||matchEX_rt)) || (MEM_MemRead && (matchMEM_rs||matchMEM_rt))).
  - An ALU result in EX or MEM is forwarded and never stalls.
  - Branches and jr take no rt dependence unless ID_UsesRt=1.
- Mul/div:
  - On EX_MulDivStart, cnt <= MULDIV_CYCLES-1 (a start while busy reloads).
  - Otherwise, if cnt!=0, cnt decrements by 1.
  - MulDivBusy = (cnt!=0), registered output.
  - md_stall = MulDivBusy && (ID_ReadHiLo || ID_MulDiv).
- stall = load_stall || br_stall || md_stall. When stall=1: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0.
- IF_ID_Flush = (ID_PCSrc!=00) && !stall. Stall has priority, because the branch decision is not valid while its operands are pending.
- All stall/flush outputs are combinational from the current inputs and cnt, with zero-cycle latency.
- StallCycles increments on every clock edge where stall=1, and saturates at all-ones.
- A stall persists until its cause clears:
  - load-use: 1 cycle.
  - branch on load in EX: 2 cycles; branch on load in MEM: 1 cycle.
  - mul/div: until cnt reaches 0.
- Register 0 never causes a stall.
- Reset asserted mid-stall clears cnt immediately, and outputs return to their pass values.

Test Plan:
1. EX: lw $8 (EX_MemRead=1, EX_Rw=8); ID: add with rs=8 (UsesRs=1) -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for one cycle; StallCycles 0->1.
2. EX: lw $0; ID: rs=0 -> no stall. EX: add writing $8 (RegWrite=1, MemRead=0); ID: beq rs=8, PCSrc=01 -> no stall, IF_ID_Flush=1.
3. beq rs=5 in ID with lw $5 in EX, followed next cycle by lw in MEM -> stall=1 for 2 consecutive cycles, IF_ID_Flush=0 throughout; then IF_ID_Flush=1 when PCSrc=01.
4. MULDIV_CYCLES=4: pulse EX_MulDivStart, then mflo in ID -> MulDivBusy high for 3 cycles, stall for those 3 cycles, release on cycle 4; StallCycles=3.
5. rst_n low while cnt=2 and mflo is in ID -> MulDivBusy=0 and PC_Write=1 immediately (asynchronous), StallCycles=0.
6. Force stall for 2^CNT_W+5 cycles with CNT_W=4 -> StallCycles holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// Stall/flush control for the 5-stage MIPS pipeline: load-use, ID-stage branch operands,
// and HI/LO access while the multi-cycle mul/div unit is still computing.
module pipeline_hazard_unit #(
  parameter int unsigned MULDIV_CYCLES = 32,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic [2:0]       BranchType,
  input  logic [1:0]       ID_PCSrc,
  input  logic             ID_ReadHiLo,
  input  logic             ID_MulDiv,
  input  logic [4:0]       EX_Rw,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       MEM_Rw,
  input  logic             MEM_MemRead,
  input  logic             EX_MulDivStart,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MulDivBusy,
  output logic [CNT_W-1:0] StallCycles
);

  localparam int unsigned MdW = 8;
  localparam logic [MdW-1:0] MdReload = MdW'(MULDIV_CYCLES - 1);

  logic [MdW-1:0]   r_md_cnt;
  logic [MdW-1:0]   w_md_cnt_d;
  logic             r_md_busy;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] w_stall_cnt_d;

  logic w_match_ex_rs;
  logic w_match_ex_rt;
  logic w_match_mem_rs;
  logic w_match_mem_rt;
  logic w_br_id;
  logic w_load_stall;
  logic w_br_stall;
  logic w_md_stall;
  logic w_stall;

  // EX_RegWrite is accepted but unused: ALU results in EX/MEM are always forwarded.
  logic w_unused;
  assign w_unused = EX_RegWrite;

  // Register 0 is hardwired to zero, so it never carries a true dependence.
  always_comb begin
    w_match_ex_rs  = ID_UsesRs && (ID_rs == EX_Rw)  && (EX_Rw  != 5'd0);
    w_match_ex_rt  = ID_UsesRt && (ID_rt == EX_Rw)  && (EX_Rw  != 5'd0);
    w_match_mem_rs = ID_UsesRs && (ID_rs == MEM_Rw) && (MEM_Rw != 5'd0);
    w_match_mem_rt = ID_UsesRt && (ID_rt == MEM_Rw) && (MEM_Rw != 5'd0);
  end

  always_comb begin
    w_br_id      = (BranchType != 3'd0) || (ID_PCSrc == 2'b11);
    w_load_stall = EX_MemRead && (w_match_ex_rs || w_match_ex_rt);
    w_br_stall   = w_br_id &&
                   ((EX_MemRead  && (w_match_ex_rs  || w_match_ex_rt)) ||
                    (MEM_MemRead && (w_match_mem_rs || w_match_mem_rt)));
    w_md_stall   = r_md_busy && (ID_ReadHiLo || ID_MulDiv);
    w_stall      = w_load_stall || w_br_stall || w_md_stall;
  end

  // Stall wins over the redirect flush: the branch outcome is bogus while operands pend.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    if (w_stall) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end else if (ID_PCSrc != 2'b00) begin
      IF_ID_Flush = 1'b1;
    end
  end

  always_comb begin
    w_md_cnt_d = r_md_cnt;
    if (EX_MulDivStart) begin
      w_md_cnt_d = MdReload;
    end else if (r_md_cnt != '0) begin
      w_md_cnt_d = r_md_cnt - MdW'(1);
    end
  end

  always_comb begin
    w_stall_cnt_d = r_stall_cnt;
    if (w_stall && (r_stall_cnt != '1)) begin
      w_stall_cnt_d = r_stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt    <= '0;
      r_md_busy   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_md_cnt    <= w_md_cnt_d;
      r_md_busy   <= (w_md_cnt_d != '0);
      r_stall_cnt <= w_stall_cnt_d;
    end
  end

  assign MulDivBusy  = r_md_busy;
  assign StallCycles = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Randomized and directed checks of pipeline_hazard_unit against a behavioural model.
module tb_pipeline_hazard_unit;

  localparam int MD  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    ID_rs, ID_rt, EX_Rw, MEM_Rw;
  logic          ID_UsesRs, ID_UsesRt, ID_ReadHiLo, ID_MulDiv;
  logic [2:0]    BranchType;
  logic [1:0]    ID_PCSrc;
  logic          EX_RegWrite, EX_MemRead, MEM_MemRead, EX_MulDivStart;
  logic          PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MulDivBusy;
  logic [CW-1:0] StallCycles;

  int n_pass  = 0;
  int n_total = 0;
  int m_cnt   = 0;
  int m_stalls = 0;

  pipeline_hazard_unit #(
    .MULDIV_CYCLES(MD),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ID_rs         (ID_rs),
    .ID_rt         (ID_rt),
    .ID_UsesRs     (ID_UsesRs),
    .ID_UsesRt     (ID_UsesRt),
    .BranchType    (BranchType),
    .ID_PCSrc      (ID_PCSrc),
    .ID_ReadHiLo   (ID_ReadHiLo),
    .ID_MulDiv     (ID_MulDiv),
    .EX_Rw         (EX_Rw),
    .EX_RegWrite   (EX_RegWrite),
    .EX_MemRead    (EX_MemRead),
    .MEM_Rw        (MEM_Rw),
    .MEM_MemRead   (MEM_MemRead),
    .EX_MulDivStart(EX_MulDivStart),
    .PC_Write      (PC_Write),
    .IF_ID_Write   (IF_ID_Write),
    .IF_ID_Flush   (IF_ID_Flush),
    .ID_EX_Flush   (ID_EX_Flush),
    .MulDivBusy    (MulDivBusy),
    .StallCycles   (StallCycles)
  );

  always #5 clk = ~clk;

  function automatic bit reads(input logic [4:0] r, input logic uses, input logic [4:0] dst);
    return uses && (r == dst) && (dst != 5'd0);
  endfunction

  // Does the ID instruction have to wait this cycle?
  function automatic bit exp_stall();
    bit on_ex, on_mem, is_br;
    on_ex  = reads(ID_rs, ID_UsesRs, EX_Rw)  || reads(ID_rt, ID_UsesRt, EX_Rw);
    on_mem = reads(ID_rs, ID_UsesRs, MEM_Rw) || reads(ID_rt, ID_UsesRt, MEM_Rw);
    is_br  = (BranchType != 0) || (ID_PCSrc == 2'b11);
    if (EX_MemRead && on_ex) return 1'b1;
    if (is_br && MEM_MemRead && on_mem) return 1'b1;
    if ((m_cnt > 0) && (ID_ReadHiLo || ID_MulDiv)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    ID_rs = 0; ID_rt = 0; ID_UsesRs = 0; ID_UsesRt = 0; BranchType = 0; ID_PCSrc = 0;
    ID_ReadHiLo = 0; ID_MulDiv = 0; EX_Rw = 0; EX_RegWrite = 0; EX_MemRead = 0;
    MEM_Rw = 0; MEM_MemRead = 0; EX_MulDivStart = 0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    bit s;
    s = exp_stall();
    @(posedge clk);
    if (rst_n) begin
      if (EX_MulDivStart) m_cnt = MD - 1;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
      if (s && m_stalls < SAT) m_stalls = m_stalls + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    m_cnt = 0;
    m_stalls = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    n_total++;
    if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MulDivBusy} !== 5'b11000)
      $display("FAIL reset_ctrl got=%b want=11000",
               {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MulDivBusy});
    else n_pass++;
    n_total++;
    if (StallCycles !== 0) $display("FAIL reset_cnt got=%0d want=0", StallCycles);
    else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    EX_MemRead = 1; EX_Rw = 8; EX_RegWrite = 1; ID_rs = 8; ID_UsesRs = 1;
    #3;
    n_total++;
    if ({PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush} !== 4'b0010)
      $display("FAIL load_use_stall got=%b want=0010",
               {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush});
    else n_pass++;
    tick();
    EX_MemRead = 0; EX_RegWrite = 0; EX_Rw = 0; MEM_MemRead = 1; MEM_Rw = 8;
    #3;
    n_total++;
    if ({PC_Write, ID_EX_Flush} !== 2'b10)
      $display("FAIL load_use_release got=%b want=10", {PC_Write, ID_EX_Flush});
    else n_pass++;
    n_total++;
    if (StallCycles !== 1) $display("FAIL load_use_cnt got=%0d want=1", StallCycles);
    else n_pass++;
    tick();
  endtask

  task automatic test_no_stall();
    do_reset();
    EX_MemRead = 1; EX_Rw = 0; ID_rs = 0; ID_UsesRs = 1;
    #3;
    n_total++;
    if (PC_Write !== 1'b1) $display("FAIL reg0_nostall got=%b want=1", PC_Write);
    else n_pass++;
    tick();
    idle();
    EX_RegWrite = 1; EX_Rw = 8; ID_rs = 8; ID_UsesRs = 1; BranchType = 1; ID_PCSrc = 2'b01;
    #3;
    n_total++;
    if ({PC_Write, ID_EX_Flush, IF_ID_Flush} !== 3'b101)
      $display("FAIL alu_fwd_branch got=%b want=101", {PC_Write, ID_EX_Flush, IF_ID_Flush});
    else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_branch_load();
    do_reset();
    BranchType = 1; ID_PCSrc = 2'b01; ID_rs = 5; ID_UsesRs = 1;
    EX_MemRead = 1; EX_Rw = 5;
    #3;
    n_total++;
    if ({PC_Write, ID_EX_Flush, IF_ID_Flush} !== 3'b010)
      $display("FAIL br_load_ex got=%b want=010", {PC_Write, ID_EX_Flush, IF_ID_Flush});
    else n_pass++;
    tick();
    EX_MemRead = 0; EX_Rw = 0; MEM_MemRead = 1; MEM_Rw = 5;
    #3;
    n_total++;
    if ({PC_Write, ID_EX_Flush, IF_ID_Flush} !== 3'b010)
      $display("FAIL br_load_mem got=%b want=010", {PC_Write, ID_EX_Flush, IF_ID_Flush});
    else n_pass++;
    tick();
    MEM_MemRead = 0; MEM_Rw = 0;
    #3;
    n_total++;
    if ({PC_Write, ID_EX_Flush, IF_ID_Flush} !== 3'b101)
      $display("FAIL br_release got=%b want=101", {PC_Write, ID_EX_Flush, IF_ID_Flush});
    else n_pass++;
    n_total++;
    if (StallCycles !== 2) $display("FAIL br_cnt got=%0d want=2", StallCycles);
    else n_pass++;
    // rt on a load does not matter unless the branch reads rt.
    ID_rt = 9; ID_UsesRt = 0; MEM_MemRead = 1; MEM_Rw = 9;
    #1;
    n_total++;
    if (PC_Write !== 1'b1) $display("FAIL br_rt_unused got=%b want=1", PC_Write);
    else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_muldiv();
    int busy_n = 0;
    int stall_n = 0;
    do_reset();
    EX_MulDivStart = 1;
    tick();
    EX_MulDivStart = 0; ID_ReadHiLo = 1;
    for (int i = 0; i < 5; i++) begin
      #3;
      if (MulDivBusy) busy_n++;
      if (!PC_Write) stall_n++;
      tick();
    end
    n_total++;
    if (busy_n !== MD - 1) $display("FAIL md_busy_cycles got=%0d want=%0d", busy_n, MD - 1);
    else n_pass++;
    n_total++;
    if (stall_n !== MD - 1) $display("FAIL md_stall_cycles got=%0d want=%0d", stall_n, MD - 1);
    else n_pass++;
    n_total++;
    if (StallCycles !== CW'(MD - 1)) $display("FAIL md_cnt got=%0d want=%0d", StallCycles, MD - 1);
    else n_pass++;
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    EX_MulDivStart = 1;
    tick();
    EX_MulDivStart = 0; ID_ReadHiLo = 1;
    tick();
    #1;
    n_total++;
    if (PC_Write !== 1'b0) $display("FAIL mid_pre_stall got=%b want=0", PC_Write);
    else n_pass++;
    rst_n = 1'b0;
    m_cnt = 0;
    m_stalls = 0;
    #1;
    n_total++;
    if ({MulDivBusy, PC_Write} !== 2'b01)
      $display("FAIL mid_reset got=%b want=01", {MulDivBusy, PC_Write});
    else n_pass++;
    n_total++;
    if (StallCycles !== 0) $display("FAIL mid_reset_cnt got=%0d want=0", StallCycles);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_saturate();
    do_reset();
    EX_MemRead = 1; EX_Rw = 3; ID_rs = 3; ID_UsesRs = 1;
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      #3;
      n_total++;
      if (StallCycles !== CW'(m_stalls))
        $display("FAIL sat_step got=%0d want=%0d", StallCycles, m_stalls);
      else n_pass++;
      tick();
    end
    n_total++;
    if (StallCycles !== CW'(SAT)) $display("FAIL sat_hold got=%0d want=%0d", StallCycles, SAT);
    else n_pass++;
    idle();
  endtask

  task automatic test_random();
    bit es;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ID_rs = 5'($urandom_range(0, 3)); ID_rt = 5'($urandom_range(0, 3));
      ID_UsesRs = 1'($urandom); ID_UsesRt = 1'($urandom);
      BranchType = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      ID_PCSrc = 2'($urandom);
      ID_ReadHiLo = ($urandom_range(0, 5) == 0); ID_MulDiv = ($urandom_range(0, 7) == 0);
      EX_Rw = 5'($urandom_range(0, 3)); EX_RegWrite = 1'($urandom);
      EX_MemRead = ($urandom_range(0, 2) == 0);
      MEM_Rw = 5'($urandom_range(0, 3)); MEM_MemRead = ($urandom_range(0, 2) == 0);
      EX_MulDivStart = ($urandom_range(0, 11) == 0);
      #3;
      es = exp_stall();
      n_total++;
      if (PC_Write !== !es) $display("FAIL rnd_pc i=%0d got=%b want=%b", i, PC_Write, !es);
      else n_pass++;
      n_total++;
      if (IF_ID_Write !== !es) $display("FAIL rnd_ifid_wr i=%0d got=%b want=%b", i, IF_ID_Write, !es);
      else n_pass++;
      n_total++;
      if (ID_EX_Flush !== es) $display("FAIL rnd_idex_fl i=%0d got=%b want=%b", i, ID_EX_Flush, es);
      else n_pass++;
      n_total++;
      if (IF_ID_Flush !== ((ID_PCSrc != 0) && !es))
        $display("FAIL rnd_ifid_fl i=%0d got=%b want=%b", i, IF_ID_Flush, (ID_PCSrc != 0) && !es);
      else n_pass++;
      n_total++;
      if (MulDivBusy !== (m_cnt > 0))
        $display("FAIL rnd_busy i=%0d got=%b want=%b", i, MulDivBusy, m_cnt > 0);
      else n_pass++;
      n_total++;
      if (StallCycles !== CW'(m_stalls))
        $display("FAIL rnd_cnt i=%0d got=%0d want=%0d", i, StallCycles, m_stalls);
      else n_pass++;
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_load();
    test_muldiv();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
